// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    // Requester identity, also used as the round-robin history value.
    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

    // Debug bus-lock state.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // The requester that should win a tie, given the one served last.
    function automatic req_id_t other_port(input req_id_t id);
        req_id_t res;
        case (id)
            REQ_CORE: res = REQ_DBG;
            REQ_DBG:  res = REQ_CORE;
            default:  res = REQ_CORE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant generator with a debug priority override,
// a core mask and the last-granted history register.
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_core,
    input  logic req_dbg,
    input  logic prio_dbg,
    input  logic mask_core,
    output logic gnt_core,
    output logic gnt_dbg
);

    req_id_t last_gnt_r;
    req_id_t tie_winner_s;
    logic    core_act_s;
    logic    dbg_act_s;

    // Qualify raw requests: nothing is granted while reset is asserted,
    // and a masked core request is treated as absent.
    always_comb begin
        core_act_s   = req_core & ~mask_core & ~reset;
        dbg_act_s    = req_dbg & ~reset;
        tie_winner_s = other_port(last_gnt_r);
    end

    // Grant selection: override first, then tie-break, then single requester.
    always_comb begin
        gnt_core = 1'b0;
        gnt_dbg  = 1'b0;
        if (prio_dbg && dbg_act_s) begin
            gnt_dbg = 1'b1;
        end else if (core_act_s && dbg_act_s) begin
            if (tie_winner_s == REQ_CORE) begin
                gnt_core = 1'b1;
            end else begin
                gnt_dbg = 1'b1;
            end
        end else if (core_act_s) begin
            gnt_core = 1'b1;
        end else if (dbg_act_s) begin
            gnt_dbg = 1'b1;
        end else begin
            gnt_core = 1'b0;
            gnt_dbg  = 1'b0;
        end
    end

    // History register: reset to debug so the core wins the first tie;
    // idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= REQ_DBG;
        end else if (gnt_core) begin
            last_gnt_r <= REQ_CORE;
        end else if (gnt_dbg) begin
            last_gnt_r <= REQ_DBG;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store port and
// the debug/loader port. Grants are combinational; read data returns one
// cycle after the grant and is routed to the port that issued the read.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    lock_state_t       lock_state_r;
    lock_state_t       lock_state_nxt_s;
    logic              locked_s;
    logic              prio_dbg_s;
    logic              gnt_core_s;
    logic              gnt_dbg_s;
    logic              any_gnt_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              rsp_pend_r;
    req_id_t           rsp_owner_r;
    logic              rsp_live_s;

    // Override inputs: a held lock owns the bus outright (the core stays
    // masked even on a cycle where debug drops its request); halt only
    // gives debug precedence.
    always_comb begin
        locked_s   = (lock_state_r == LOCKED);
        prio_dbg_s = locked_s | halt;
    end

    dmem_arbiter_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req_core  (core_req),
        .req_dbg   (dbg_req),
        .prio_dbg  (prio_dbg_s),
        .mask_core (locked_s),
        .gnt_core  (gnt_core_s),
        .gnt_dbg   (gnt_dbg_s)
    );

    // Select the granted port's command fields; zero when idle.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        if (gnt_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_wdata_s = dbg_wdata;
        end else if (gnt_core_s) begin
            sel_we_s    = core_we;
            sel_addr_s  = core_addr;
            sel_wdata_s = core_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = {ADDR_W{1'b0}};
            sel_wdata_s = {DATA_W{1'b0}};
        end
    end

    // Memory strobes and request-side handshake outputs. Stall is masked
    // during reset so every output is quiet in the reset cycle.
    always_comb begin
        any_gnt_s   = gnt_core_s | gnt_dbg_s;
        mem_wr      = any_gnt_s & sel_we_s;
        mem_rd      = any_gnt_s & ~sel_we_s;
        mem_addr    = sel_addr_s;
        mem_wr_data = sel_wdata_s;
        core_gnt    = gnt_core_s;
        dbg_gnt     = gnt_dbg_s;
        core_stall  = core_req & ~gnt_core_s & ~reset;
    end

    // Lock FSM next state: enter on a locked debug grant, leave as soon as
    // debug stops asking or releases the lock.
    always_comb begin
        lock_state_nxt_s = lock_state_r;
        case (lock_state_r)
            UNLOCKED: begin
                if (gnt_dbg_s && dbg_lock) begin
                    lock_state_nxt_s = LOCKED;
                end else begin
                    lock_state_nxt_s = UNLOCKED;
                end
            end
            LOCKED: begin
                if (!dbg_lock || !dbg_req) begin
                    lock_state_nxt_s = UNLOCKED;
                end else begin
                    lock_state_nxt_s = LOCKED;
                end
            end
            default: lock_state_nxt_s = UNLOCKED;
        endcase
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_r <= UNLOCKED;
        end else begin
            lock_state_r <= lock_state_nxt_s;
        end
    end

    // Read response tracking: remember that a read was issued and by whom.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend_r  <= 1'b0;
            rsp_owner_r <= REQ_CORE;
        end else if (any_gnt_s && !sel_we_s) begin
            rsp_pend_r  <= 1'b1;
            rsp_owner_r <= gnt_dbg_s ? REQ_DBG : REQ_CORE;
        end else begin
            rsp_pend_r  <= 1'b0;
            rsp_owner_r <= rsp_owner_r;
        end
    end

    // Route memory read data to the owner; a response caught by reset is
    // dropped rather than delivered.
    always_comb begin
        rsp_live_s  = rsp_pend_r & ~reset;
        core_rvalid = rsp_live_s & (rsp_owner_r == REQ_CORE);
        dbg_rvalid  = rsp_live_s & (rsp_owner_r == REQ_DBG);
        if (core_rvalid) begin
            core_rdata = mem_rd_data;
        end else begin
            core_rdata = {DATA_W{1'b0}};
        end
        if (dbg_rvalid) begin
            dbg_rdata = mem_rd_data;
        end else begin
            dbg_rdata = {DATA_W{1'b0}};
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-port data memory (9-bit word address, DATA_W data) between the core load/store port and a debug/loader port.
- Sits between the datapath's memory interface and the data memory.
- Drives the memory wr/rd/addr/wr_data strobes and routes read data back to the owning requester.
- Generates a core stall when the core is not granted.
- Round-robin by default; strict debug priority while the core is halted; optional debug bus lock for multi-word bursts.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, memory word-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
halt  in  1  core halted; debug port gets strict priority
core_req  in  1  core memory request
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core request accepted this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
dbg_req  in  1  debug memory request
dbg_we  in  1  1 = write, 0 = read
dbg_lock  in  1  hold grant across consecutive debug requests
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_gnt  out  1  debug request accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wr_data  out  DATA_W  memory write data
mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_rd

Behaviour:
- Accepts at most one request per cycle. Grants are combinational from the current-cycle requests and registered state.
- Grant selection, in priority order:
  1. Locked: if lock_state == LOCKED and dbg_req, grant debug.
  2. Halt priority: else if halt and dbg_req, grant debug.
  3. Single request: else if exactly one requester is active, grant it.
  4. Both active: grant the port that is not last_gnt.
- When a port is granted:
  - mem_rd = ~we, mem_wr = we.
  - mem_addr and mem_wr_data are muxed from the granted port.
  - With no grant, mem_rd = mem_wr = 0 and mem_addr/mem_wr_data = 0.
- last_gnt register: updated to the granted port on every grant; unchanged on idle cycles.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED on a debug grant with dbg_lock = 1.
  - LOCKED -> UNLOCKED on any cycle with dbg_lock = 0, or with dbg_req = 0.
  - While LOCKED, the core is never granted, even if dbg_req = 0 that same cycle.
  - Halt does not affect the lock FSM.
- Read response pipeline:
  - Registers rsp_pend (1 bit) and rsp_owner (0 = core, 1 = debug) are set on a granted read.
  - In the following cycle, the owner's rvalid = 1 and its rdata = mem_rd_data (combinational pass-through). The other port's rvalid = 0 and its rdata = 0.
  - Fixed read latency of 1 cycle after grant. Back-to-back reads from alternating ports are supported with no bubble.
- Writes complete in the grant cycle; no response is generated.
- core_stall = core_req & ~core_gnt, combinational.
- Simultaneous events:
  - A new grant and a pending response in the same cycle are independent and both occur.
  - halt rising while the core is mid-response: the response is still delivered.
- Reset:
  - last_gnt = debug, so the core wins the first tie.
  - lock_state = UNLOCKED, rsp_pend = 0.
  - All outputs are 0 in the reset cycle; no grants while reset = 1.
  - A pending read is dropped, and no rvalid appears in the cycle after reset.
- Requesters must hold req, addr, we and wdata stable until granted. The arbiter does not latch unaccepted requests.

Decomposition:
Shared package holds:
- Requester id typedef: enum REQ_CORE = 0, REQ_DBG = 1.
- Lock state enum: UNLOCKED, LOCKED.
- ADDR_W / DATA_W defaults.

One sub-module, rr_arb2: two-input round-robin grant with priority override and last_gnt register. The response pipeline and lock FSM stay in dmem_arbiter.

Test Plan:
- Core-only read: core_req = 1, we = 0, addr = 0x010; mem_rd_data = 0xDEADBEEF next cycle.
  -> core_gnt, mem_rd, mem_addr = 0x010 in cycle N; core_rvalid = 1 and core_rdata = 0xDEADBEEF in N+1; dbg_rvalid = 0.
- Contention: both ports request reads continuously for 4 cycles after reset.
  -> grants alternate core, dbg, core, dbg; core_stall = 1 in cycles 2 and 4; rvalid alternates one cycle later.
- Halt priority: halt = 1, both requesting for 3 cycles.
  -> dbg_gnt in all 3 cycles; core_stall = 1 throughout.
- Lock burst: dbg writes 0x1..0x4 to addresses 0x100..0x103 with dbg_lock = 1, core_req = 1 throughout; dbg_lock drops on the last beat.
  -> 4 consecutive dbg grants with mem_wr and the correct addr/data; core granted in the next cycle.
- Reset mid-read: core read granted in cycle N, reset = 1 in N+1.
  -> core_rvalid = 0 in N+1 and N+2; first tie after reset goes to the core.
- Write/read same address: core writes 0xCAFE to 0x05, dbg reads 0x05 the next cycle.
  -> mem_wr in cycle N, mem_rd in N+1, dbg_rvalid in N+2 carrying mem_rd_data.
